// File: rtl/crc_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : crc_frame_seq (+ bit-serial engine crc)
//  Purpose  : Byte-stream front end for a bit-serial 8-bit CRC engine.
//             Bytes arrive over a valid/ready stream. Each byte is shifted
//             into the engine one bit per clock, MSB-first or LSB-first.
//             When the last byte of a frame has been shifted, the finished
//             CRC is held on a valid/ready output until it is taken.
//  Ports    : clk        free-running clock
//             rst        synchronous reset, active-low
//             s_valid    input byte valid
//             s_ready    block can accept a byte this cycle
//             s_data     input byte
//             s_last     byte closes the frame
//             abort      discard the current frame
//             crc_valid  crc_data holds the final frame CRC
//             crc_ready  consumer accepts the CRC
//             crc_data   registered frame CRC
//             frame_len  bytes in current/last frame (saturating)
//             busy       sequencer not idle
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  crc : bit-serial 8-bit CRC engine
//    clk, rst (sync, active-high, loads INIT), enable (shift one bit),
//    data (serial input bit), crc_out (output-mapped CRC value)
// ----------------------------------------------------------------------------
module crc #(
   parameter logic [7:0] POLY    = 8'h07,
   parameter logic [7:0] INIT    = 8'h00,
   parameter int         REF_OUT = 0,
   parameter logic [7:0] XOR_OUT = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       data,
   output logic [7:0] crc_out
);

   logic [7:0] lfsr;
   logic [7:0] lfsr_nxt;
   logic [7:0] lfsr_view;
   logic       fb;

   function automatic logic [7:0] map_out(input logic [7:0] v);
      logic [7:0] r;
      r = v;
      if (REF_OUT != 0) begin
         for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
         end
      end
      return r ^ XOR_OUT;
   endfunction

   always_comb begin
      fb       = data ^ lfsr[7];
      lfsr_nxt = {lfsr[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= INIT;
      end else if (enable) begin
         lfsr <= lfsr_nxt;
      end
   end

   // crc_out looks ahead by the bit being shifted this cycle, so the value
   // captured on the edge that shifts the final bit is the complete CRC.
   assign lfsr_view = enable ? lfsr_nxt : lfsr;
   assign crc_out   = map_out(lfsr_view);

endmodule

// ----------------------------------------------------------------------------
//  crc_frame_seq : byte sequencer around one crc engine
// ----------------------------------------------------------------------------
module crc_frame_seq #(
   parameter logic [7:0] POLY    = 8'h07,
   parameter logic [7:0] INIT    = 8'h00,
   parameter int         REF_IN  = 0,
   parameter int         REF_OUT = 0,
   parameter logic [7:0] XOR_OUT = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   input  logic        abort,
   output logic        crc_valid,
   input  logic        crc_ready,
   output logic [7:0]  crc_data,
   output logic [15:0] frame_len,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       last_f;
   logic       xfer;
   logic       last_bit;
   logic       ser_bit;
   logic       eng_en;
   logic       eng_rst;
   logic [7:0] eng_crc;

   // Final shift of a byte: the byte boundary where new data can be taken
   assign last_bit = (state == S_SHIFT) && (bit_cnt == 3'd7);
   assign xfer     = s_valid & s_ready;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
               if (bit_cnt == 3'd7) begin
                  if (last_f)    state_nxt = S_DONE;
                  else if (xfer) state_nxt = S_SHIFT;
                  else           state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (xfer) state_nxt = S_SHIFT;
            end
            S_DONE: begin
               if (crc_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      s_ready   = 1'b0;
      crc_valid = 1'b0;
      busy      = 1'b1;
      eng_en    = 1'b0;
      case (state)
         S_IDLE: begin
            s_ready = 1'b1;
            busy    = 1'b0;
         end
         S_SHIFT: begin
            s_ready = (bit_cnt == 3'd7) && !last_f;
            eng_en  = 1'b1;
         end
         S_WAIT: begin
            s_ready = 1'b1;
         end
         S_DONE: begin
            crc_valid = 1'b1;
         end
         default: begin
            s_ready = 1'b0;
         end
      endcase
      // abort wins over any byte offered in the same cycle
      if (abort) s_ready = 1'b0;
   end

   // Serial bit selection and engine control. Holding the engine in reset
   // throughout IDLE keeps it at INIT, so a new frame needs no clear cycle.
   assign ser_bit = (REF_IN != 0) ? shreg[0] : shreg[7];
   assign eng_rst = (~rst) | (state == S_IDLE) | abort;

   crc #(
      .POLY    (POLY),
      .INIT    (INIT),
      .REF_OUT (REF_OUT),
      .XOR_OUT (XOR_OUT)
   ) u_crc (
      .clk     (clk),
      .rst     (eng_rst),
      .enable  (eng_en),
      .data    (ser_bit),
      .crc_out (eng_crc)
   );

   // ------------------------------------------------------------------
   // Byte shift register, bit counter and last-byte flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg   <= 8'h00;
         bit_cnt <= 3'd0;
         last_f  <= 1'b0;
      end else if (xfer) begin
         shreg   <= s_data;
         bit_cnt <= 3'd0;
         last_f  <= s_last;
      end else if (state == S_SHIFT) begin
         shreg   <= (REF_IN != 0) ? {1'b0, shreg[7:1]} : {shreg[6:0], 1'b0};
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // ------------------------------------------------------------------
   // Frame length: restarts at 1 on the first byte of a frame, otherwise
   // counts up and sticks at all-ones.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_len <= 16'h0000;
      end else if (abort) begin
         frame_len <= 16'h0000;
      end else if (xfer) begin
         if (state == S_IDLE) begin
            frame_len <= 16'h0001;
         end else if (frame_len != 16'hFFFF) begin
            frame_len <= frame_len + 16'h0001;
         end
      end
   end

   // ------------------------------------------------------------------
   // Result capture on the edge that shifts the final bit of the frame
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         crc_data <= 8'h00;
      end else if (last_bit && last_f && !abort) begin
         crc_data <= eng_crc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_frame_seq
//  Purpose  : Self-checking bench for crc_frame_seq. Four instances share
//             one stimulus stream (CRC-8, MAXIM, ROHC, ITU); a scoreboard
//             holds expected CRCs pushed when a frame is driven and popped
//             when the result appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crc_frame_seq;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        abort;
   logic        crc_ready;

   logic        s_ready,   s_ready_mx,   s_ready_rh,   s_ready_it;
   logic        crc_valid, crc_valid_mx, crc_valid_rh, crc_valid_it;
   logic [7:0]  crc_data,  crc_data_mx,  crc_data_rh,  crc_data_it;
   logic [15:0] frame_len, frame_len_mx, frame_len_rh, frame_len_it;
   logic        busy,      busy_mx,      busy_rh,      busy_it;

   typedef struct {
      logic [31:0] crcs;   // {crc8, maxim, rohc, itu}
      int          len;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  fbuf [0:15];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          t_xfer   = 0;
   int          t_first  = 0;
   logic        vprev    = 1'b0;

   crc_frame_seq #(.POLY(8'h07), .INIT(8'h00), .REF_IN(0), .REF_OUT(0), .XOR_OUT(8'h00)) u_crc8 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .abort(abort), .crc_valid(crc_valid), .crc_ready(crc_ready),
      .crc_data(crc_data), .frame_len(frame_len), .busy(busy));

   crc_frame_seq #(.POLY(8'h31), .INIT(8'h00), .REF_IN(1), .REF_OUT(1), .XOR_OUT(8'h00)) u_maxim (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_mx), .s_data(s_data),
      .s_last(s_last), .abort(abort), .crc_valid(crc_valid_mx), .crc_ready(crc_ready),
      .crc_data(crc_data_mx), .frame_len(frame_len_mx), .busy(busy_mx));

   crc_frame_seq #(.POLY(8'h07), .INIT(8'hFF), .REF_IN(1), .REF_OUT(1), .XOR_OUT(8'h00)) u_rohc (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_rh), .s_data(s_data),
      .s_last(s_last), .abort(abort), .crc_valid(crc_valid_rh), .crc_ready(crc_ready),
      .crc_data(crc_data_rh), .frame_len(frame_len_rh), .busy(busy_rh));

   crc_frame_seq #(.POLY(8'h07), .INIT(8'h00), .REF_IN(0), .REF_OUT(0), .XOR_OUT(8'h55)) u_itu (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_it), .s_data(s_data),
      .s_last(s_last), .abort(abort), .crc_valid(crc_valid_it), .crc_ready(crc_ready),
      .crc_data(crc_data_it), .frame_len(frame_len_it), .busy(busy_it));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Byte-wise catalogue-form CRC over fbuf[0..n-1]
   function automatic logic [7:0] model(input int n, input logic [7:0] poly, input logic [7:0] init,
                                        input bit ri, input bit ro, input logic [7:0] xo);
      logic [7:0] c;
      logic [7:0] b;
      logic [7:0] r;
      c = init;
      for (int i = 0; i < n; i++) begin
         b = fbuf[i];
         if (ri) begin
            r = b;
            for (int k = 0; k < 8; k++) b[k] = r[7-k];
         end
         c = c ^ b;
         for (int k = 0; k < 8; k++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
         end
      end
      if (ro) begin
         r = c;
         for (int k = 0; k < 8; k++) c[k] = r[7-k];
      end
      return c ^ xo;
   endfunction

   // Scoreboard consumer: compare on each rising crc_valid
   always @(negedge clk) begin
      if (crc_valid && !vprev) begin
         if (sb.size() == 0) begin
            check("unexp_crc", {31'd0, crc_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_crc8",  {24'd0, crc_data},    {24'd0, e.crcs[31:24]});
            check("sb_maxim", {24'd0, crc_data_mx}, {24'd0, e.crcs[23:16]});
            check("sb_rohc",  {24'd0, crc_data_rh}, {24'd0, e.crcs[15:8]});
            check("sb_itu",   {24'd0, crc_data_it}, {24'd0, e.crcs[7:0]});
            check("sb_len",   {16'd0, frame_len},   e.len);
         end
      end
      vprev = crc_valid;
   end

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int w = 0; w < 50 && !ok; w++) begin
         @(negedge clk);
         if (s_ready && !abort) begin
            ok     = 1'b1;
            t_xfer = cyc;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_data  = 8'h00;
      s_last  = 1'b0;
      check("xfer_ok", {31'd0, ok}, 32'd1);
   endtask

   task automatic send_frame(input int n, input int maxgap);
      exp_t e;
      int   g;
      e.crcs = {model(n, 8'h07, 8'h00, 1'b0, 1'b0, 8'h00),
                model(n, 8'h31, 8'h00, 1'b1, 1'b1, 8'h00),
                model(n, 8'h07, 8'hFF, 1'b1, 1'b1, 8'h00),
                model(n, 8'h07, 8'h00, 1'b0, 1'b0, 8'h55)};
      e.len  = n;
      sb.push_back(e);
      for (int i = 0; i < n; i++) begin
         send_byte(fbuf[i], (i == n - 1));
         if (i == 0) t_first = t_xfer;
         g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
         if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_crc(output int tseen);
      bit ok;
      ok    = 1'b0;
      tseen = 0;
      for (int w = 0; w < 40 && !ok; w++) begin
         @(negedge clk);
         if (crc_valid) begin
            ok    = 1'b1;
            tseen = cyc;
         end
      end
      check("crc_seen", {31'd0, ok}, 32'd1);
   endtask

   task automatic load_check_string();
      for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
   endtask

   initial begin
      int t;
      int hi;
      rst       = 1'b0;
      s_valid   = 1'b0;
      s_data    = 8'h00;
      s_last    = 1'b0;
      abort     = 1'b0;
      crc_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready",   {31'd0, s_ready},   32'd1);
      check("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_crc_data",  {24'd0, crc_data},  32'd0);
      check("rst_frame_len", {16'd0, frame_len}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Back-to-back check string
      load_check_string();
      send_frame(9, 0);
      wait_crc(t);
      check("b2b_crc8",    {24'd0, crc_data},  32'hF4);
      check("b2b_itu",     {24'd0, crc_data_it}, 32'hA1);
      check("b2b_len",     {16'd0, frame_len}, 32'd9);
      check("b2b_latency", t - t_first,        32'd73);
      @(posedge clk); #1;

      // Random gaps between bytes
      send_frame(9, 5);
      wait_crc(t);
      check("gap_maxim", {24'd0, crc_data_mx}, 32'hA1);
      check("gap_rohc",  {24'd0, crc_data_rh}, 32'hD0);
      check("gap_itu",   {24'd0, crc_data_it}, 32'hA1);
      @(posedge clk); #1;

      // Backpressure on the result
      crc_ready = 1'b0;
      send_frame(9, 0);
      wait_crc(t);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_valid",  {31'd0, crc_valid}, 32'd1);
         check("bp_data",   {24'd0, crc_data},  32'hF4);
         check("bp_s_ready", {31'd0, s_ready},  32'd0);
      end
      @(posedge clk); #1;
      crc_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_release_valid", {31'd0, crc_valid}, 32'd0);
      check("bp_release_busy",  {31'd0, busy},      32'd0);
      @(posedge clk); #1;
      send_frame(9, 0);
      wait_crc(t);
      check("bp_again_crc8", {24'd0, crc_data}, 32'hF4);
      @(posedge clk); #1;

      // Abort after 4 bytes, with a byte offered in the abort cycle
      for (int i = 0; i < 4; i++) send_byte(fbuf[i], 1'b0);
      repeat (10) @(posedge clk);
      #1;
      abort   = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h55;
      @(negedge clk);
      check("abort_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge clk); #1;
      abort   = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      check("abort_busy",      {31'd0, busy},      32'd0);
      check("abort_frame_len", {16'd0, frame_len}, 32'd0);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (crc_valid) hi++;
      end
      check("abort_no_valid", hi, 32'd0);
      @(posedge clk); #1;
      send_frame(9, 0);
      wait_crc(t);
      check("abort_after_crc8", {24'd0, crc_data}, 32'hF4);
      @(posedge clk); #1;

      // Reset pulse during the shift of byte 5
      for (int i = 0; i < 5; i++) send_byte(fbuf[i], 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("mrst_s_ready",   {31'd0, s_ready},   32'd1);
      check("mrst_crc_valid", {31'd0, crc_valid}, 32'd0);
      check("mrst_crc_data",  {24'd0, crc_data},  32'd0);
      check("mrst_frame_len", {16'd0, frame_len}, 32'd0);
      check("mrst_busy",      {31'd0, busy},      32'd0);
      @(posedge clk); #1;
      send_frame(9, 0);
      wait_crc(t);
      check("mrst_after_crc8", {24'd0, crc_data}, 32'hF4);
      @(posedge clk); #1;

      // Single-byte frame, then a byte offered while DONE
      fbuf[0]   = 8'h00;
      crc_ready = 1'b0;
      send_frame(1, 0);
      wait_crc(t);
      s_valid = 1'b1;
      s_data  = 8'hAA;
      s_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("done_s_ready", {31'd0, s_ready}, 32'd0);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("one_crc8", {24'd0, crc_data},  32'h00);
      check("one_len",  {16'd0, frame_len}, 32'd1);
      crc_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("one_idle_busy", {31'd0, busy},      32'd0);
      check("one_idle_len",  {16'd0, frame_len}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
